// File: rtl/id_stage_pipe_if.sv
// IF -> ID -> EX handshake and decode-bundle bus of the pipelined decode stage.
// master: the side driving instructions and consuming bundles; slave: the decode stage.
interface id_stage_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [31:0]     pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      sa;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm_ext;
    logic [31:0]     jump_target;
    logic [1:0]      instr_type;
    logic [31:0]     pc_out;
    logic            halted;

    modport master (
        output in_valid, instruction, pc, flush, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, sa, funct,
               imm_ext, jump_target, instr_type, pc_out, halted
    );

    modport slave (
        input  in_valid, instruction, pc, flush, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, sa, funct,
               imm_ext, jump_target, instr_type, pc_out, halted
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined MIPS-32 decode stage: combinational decode into a registered output
// bundle backed by one skid entry, with flush and a sticky HALT.
module id_stage_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter bit          SIGN_EXT = 1'b1,
    parameter logic [5:0]  HALT_OPC = 6'h3F
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_pipe_if.slave bus
);
    localparam int unsigned IMM_W = 16;
    localparam logic [1:0]  T_R    = 2'd0;
    localparam logic [1:0]  T_J    = 2'd1;
    localparam logic [1:0]  T_HALT = 2'd2;
    localparam logic [1:0]  T_I    = 2'd3;

    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      sa;
        logic [5:0]      funct;
        logic [XLEN-1:0] imm_ext;
        logic [31:0]     jump_target;
        logic [1:0]      itype;
        logic [31:0]     pc;
    } bundle_t;

    // Full decode of one instruction word; unused fields stay zero.
    function automatic bundle_t decode(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t          b;
        logic [5:0]       opc;
        logic [IMM_W-1:0] imm16;
        logic [31:0]      pc4;
        b      = '0;
        opc    = instr[31:26];
        imm16  = instr[15:0];
        pc4    = pc + 32'd4;
        b.opcode = opc;
        b.pc     = pc;
        if (opc == HALT_OPC) begin
            b.itype = T_HALT;
        end else if (opc == 6'h00) begin
            b.itype = T_R;
            b.rs    = instr[25:21];
            b.rt    = instr[20:16];
            b.rd    = instr[15:11];
            b.sa    = instr[10:6];
            b.funct = instr[5:0];
        end else if (opc == 6'h02 || opc == 6'h03) begin
            b.itype       = T_J;
            b.jump_target = {pc4[31:28], instr[25:0], 2'b00};
        end else begin
            b.itype = T_I;
            b.rs    = instr[25:21];
            b.rt    = instr[20:16];
            case (opc)
                6'h0C, 6'h0D, 6'h0E: b.imm_ext = XLEN'(imm16);
                6'h0F:               b.imm_ext = XLEN'({imm16, 16'h0000});
                default: begin
                    if (SIGN_EXT) b.imm_ext = XLEN'($signed(imm16));
                    else          b.imm_ext = XLEN'(imm16);
                end
            endcase
        end
        return b;
    endfunction

    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;
    logic    out_valid_q, out_valid_d;
    logic    skid_full_q, skid_full_d;
    logic    halt_seen_q, halt_seen_d;
    logic    halted_q, halted_d;
    logic    in_ready_q, in_ready_d;
    logic    accept, handoff;

    assign dec     = decode(bus.instruction, bus.pc);
    assign accept  = bus.in_valid & in_ready_q;
    assign handoff = out_valid_q & bus.out_ready;

    // Next-state: flush wins, otherwise move skid/new word into the output slot.
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q | (handoff & (out_q.itype == T_HALT));

        if (bus.flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
            // A retired HALT keeps the stage closed; an unretired one is discarded.
            halt_seen_d = halt_seen_q & halted_d;
        end else begin
            halt_seen_d = halt_seen_q | (accept & (dec.itype == T_HALT));
            if (!out_valid_q || handoff) begin
                if (skid_full_q) begin
                    out_d       = skid_q;
                    out_valid_d = 1'b1;
                    skid_full_d = 1'b0;
                end else if (accept) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d      = dec;
                skid_full_d = 1'b1;
            end
        end

        in_ready_d = ~skid_full_d & ~halt_seen_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.opcode      = out_q.opcode;
    assign bus.rs          = out_q.rs;
    assign bus.rt          = out_q.rt;
    assign bus.rd          = out_q.rd;
    assign bus.sa          = out_q.sa;
    assign bus.funct       = out_q.funct;
    assign bus.imm_ext     = out_q.imm_ext;
    assign bus.jump_target = out_q.jump_target;
    assign bus.instr_type  = out_q.itype;
    assign bus.pc_out      = out_q.pc;
    assign bus.halted      = halted_q;

endmodule
